// File: rtl/input_conditioner_bank.sv
// input_conditioner_bank
// Front-end conditioning for raw board inputs. Each switch passes through a
// two-flop synchronizer. Each button is synchronized the same way, then
// debounced: the conditioned level follows the synchronized value only after
// the two have disagreed for WAIT_TIME+1 consecutive edges. Every accepted
// transition produces a one-cycle rise or fall pulse, so one press yields one
// action downstream.
module input_conditioner_bank #(
    parameter int WIDTH         = 4,
    parameter int WAIT_TIME     = 3,
    parameter int COUNTER_WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall,
    output logic [WIDTH-1:0] sw_sync
);

    // The counter must be able to represent WAIT_TIME.
    generate
        if ((1 << COUNTER_WIDTH) <= WAIT_TIME) begin : g_bad_counter_width
            $error("input_conditioner_bank: COUNTER_WIDTH cannot hold WAIT_TIME");
        end
    endgenerate

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(WAIT_TIME);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    // Synchronizer stages: s0 may go metastable, s1 is the first usable copy.
    logic [WIDTH-1:0] btn_s0_q;
    logic [WIDTH-1:0] btn_s1_q;
    logic [WIDTH-1:0] sw_s0_q;
    logic [WIDTH-1:0] sw_s1_q;

    // Debounce state and registered edge pulses.
    logic [WIDTH-1:0]         level_q, level_d;
    logic [WIDTH-1:0]         rise_q,  rise_d;
    logic [WIDTH-1:0]         fall_q,  fall_d;
    logic [COUNTER_WIDTH-1:0] cnt_q [WIDTH];
    logic [COUNTER_WIDTH-1:0] cnt_d [WIDTH];

    // Two-flop synchronizer chains for buttons and switches.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every stage samples the
        // pre-edge value of the stage before it; blocking here would collapse
        // the chain into a single flop.
        if (reset) begin
            btn_s0_q <= '0;
            btn_s1_q <= '0;
            sw_s0_q  <= '0;
            sw_s1_q  <= '0;
        end else begin
            btn_s0_q <= btn;
            btn_s1_q <= btn_s0_q;
            sw_s0_q  <= sw;
            sw_s1_q  <= sw_s0_q;
        end
    end

    // Debounce next state: count edges of disagreement, commit on the one
    // after the count reaches WAIT_TIME, and clear the count on any agreement.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // leaves a value unassigned and no latch is inferred.
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (btn_s1_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = btn_s1_q[i];
                    rise_d[i]  = btn_s1_q[i];
                    fall_d[i]  = ~btn_s1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounce state register; reset drops any transition still being counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign sw_sync   = sw_s1_q;

endmodule

// File: tb/tb_input_conditioner_bank.sv
// tb_input_conditioner_bank
// Drives the conditioner with a phase table plus hand-written corner-case
// sequences. A cycle model (sliding window of synchronized samples) predicts
// every output; predictions are queued when stimulus is driven and popped
// when the following edge has produced the DUT response.
module tb_input_conditioner_bank;

    localparam int WIDTH     = 4;
    localparam int WAIT_TIME = 3;
    localparam int LAT       = WAIT_TIME + 2;

    typedef struct packed {
        logic [WIDTH-1:0] level;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic [WIDTH-1:0] sw;
    } obs_t;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] btn;
        logic [WIDTH-1:0] sw;
        int               cycles;
        logic [WIDTH-1:0] exp_level;
        logic [WIDTH-1:0] exp_sw;
    } phase_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] btn = '0;
    logic [WIDTH-1:0] sw = '0;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_rise;
    logic [WIDTH-1:0] btn_fall;
    logic [WIDTH-1:0] sw_sync;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [WIDTH-1:0]     m_s0 = '0, m_s1 = '0, m_sw0 = '0, m_sw1 = '0, m_level = '0;
    logic [WAIT_TIME:0]   m_hist [WIDTH];
    logic [WIDTH-1:0]     sw_cur = '0;
    obs_t                 sb_q [$];

    input_conditioner_bank #(
        .WIDTH(WIDTH), .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(3)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .sw(sw),
        .btn_level(btn_level), .btn_rise(btn_rise),
        .btn_fall(btn_fall), .sw_sync(sw_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict the post-edge outputs, compare after the edge.
    task automatic tick(input logic r, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] s);
        obs_t               exp;
        obs_t               got;
        logic [WAIT_TIME:0] win;
        reset  = r;
        btn    = b;
        sw     = s;
        sw_cur = s;
        exp.rise = '0;
        exp.fall = '0;
        if (r) begin
            m_s0 = '0; m_s1 = '0; m_sw0 = '0; m_sw1 = '0; m_level = '0;
            for (int ch = 0; ch < WIDTH; ch++) m_hist[ch] = '0;
        end else begin
            // A level flips once the last WAIT_TIME+1 synchronized samples all differ from it.
            for (int ch = 0; ch < WIDTH; ch++) begin
                win = {m_hist[ch][WAIT_TIME-1:0], m_s1[ch]};
                if (win == {(WAIT_TIME+1){~m_level[ch]}}) begin
                    m_level[ch] = m_s1[ch];
                    if (m_s1[ch]) exp.rise[ch] = 1'b1;
                    else          exp.fall[ch] = 1'b1;
                end
                m_hist[ch] = win;
            end
            m_s1  = m_s0;
            m_s0  = b;
            m_sw1 = m_sw0;
            m_sw0 = s;
        end
        exp.level = m_level;
        exp.sw    = m_sw1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        got = {btn_level, btn_rise, btn_fall, sw_sync};
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got %h expected queued entry", got);
        end else begin
            exp = sb_q.pop_front();
            check("scoreboard", 16'(got), 16'(exp));
        end
    endtask

    // Hold btn for n edges; a pulse is required only at the given indices (index 0 = first edge).
    task automatic run_seg(input string name, input logic [WIDTH-1:0] b, input int n,
                           input int rise_at, input logic [WIDTH-1:0] rise_v,
                           input int fall_at, input logic [WIDTH-1:0] fall_v);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, b, sw_cur);
            check({name, "_rise"}, 16'(btn_rise), 16'((i == rise_at) ? rise_v : 4'h0));
            check({name, "_fall"}, 16'(btn_fall), 16'((i == fall_at) ? fall_v : 4'h0));
        end
    endtask

    phase_t table_v [6];

    initial begin
        for (int ch = 0; ch < WIDTH; ch++) m_hist[ch] = '0;

        table_v[0] = '{1'b0, 4'h0, 4'h5, 8, 4'h0, 4'h5};
        table_v[1] = '{1'b0, 4'h6, 4'hC, 8, 4'h6, 4'hC};
        table_v[2] = '{1'b0, 4'h9, 4'h3, 8, 4'h9, 4'h3};
        table_v[3] = '{1'b1, 4'hF, 4'hF, 2, 4'h0, 4'h0};
        table_v[4] = '{1'b0, 4'hF, 4'h0, 8, 4'hF, 4'h0};
        table_v[5] = '{1'b0, 4'h0, 4'h7, 8, 4'h0, 4'h7};

        // Test 1: reset with buttons and switches active, then release.
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 4'hF, 4'hA);
            check("reset_outputs", 16'({btn_level, btn_rise, btn_fall, sw_sync}), 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 4'hF, 4'hA);
            check("rel_sw",    16'(sw_sync),   16'((i >= 1) ? 4'hA : 4'h0));
            check("rel_level", 16'(btn_level), 16'((i >= LAT) ? 4'hF : 4'h0));
            check("rel_rise",  16'(btn_rise),  16'((i == LAT) ? 4'hF : 4'h0));
        end
        run_seg("t1_release", 4'h0, 10, -1, 4'h0, LAT, 4'hF);

        // Phase table: settled level and switch value after each phase.
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < table_v[p].cycles; c++)
                tick(table_v[p].rst, table_v[p].btn, table_v[p].sw);
            check("tbl_level", 16'(btn_level), 16'(table_v[p].exp_level));
            check("tbl_sw",    16'(sw_sync),   16'(table_v[p].exp_sw));
        end

        // Test 2: clean press on btn[0], held 20 cycles, then released.
        run_seg("t2_press",   4'h1, 20, LAT, 4'h1, -1, 4'h0);
        check("t2_level_hi", 16'(btn_level), 16'h0001);
        run_seg("t2_release", 4'h0, 10, -1, 4'h0, LAT, 4'h1);

        // Test 3: bounce on btn[1]; one rise LAT edges after the final stable 1.
        tick(1'b0, 4'h2, sw_cur); check("t3_level", 16'(btn_level), 16'h0);
        tick(1'b0, 4'h0, sw_cur); check("t3_level", 16'(btn_level), 16'h0);
        tick(1'b0, 4'h2, sw_cur); check("t3_level", 16'(btn_level), 16'h0);
        tick(1'b0, 4'h0, sw_cur); check("t3_level", 16'(btn_level), 16'h0);
        run_seg("t3_settle",  4'h2, 12, LAT, 4'h2, -1, 4'h0);
        run_seg("t3_release", 4'h0, 10, -1, 4'h0, LAT, 4'h2);

        // Test 4: 3-cycle glitch rejected, 4-cycle pulse accepted.
        run_seg("t4_short_hi", 4'h4, 3, -1, 4'h0, -1, 4'h0);
        run_seg("t4_short_lo", 4'h0, 10, -1, 4'h0, -1, 4'h0);
        check("t4_short_level", 16'(btn_level), 16'h0);
        run_seg("t4_long_hi", 4'h4, 4, -1, 4'h0, -1, 4'h0);
        run_seg("t4_long_lo", 4'h0, 12, 1, 4'h4, LAT, 4'h4);

        // Test 5: reset three edges into a btn[3] debounce.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'h8, sw_cur);
            check("t5_pre_rise", 16'(btn_rise), 16'h0);
        end
        tick(1'b1, 4'h8, sw_cur);
        check("t5_reset", 16'({btn_level, btn_rise, btn_fall, sw_sync}), 16'h0000);
        run_seg("t5_after", 4'h8, 10, LAT, 4'h8, -1, 4'h0);
        run_seg("t5_release", 4'h0, 10, -1, 4'h0, LAT, 4'h8);

        // Test 6: three channels pressed together pulse in the same cycle.
        run_seg("t6_press",   4'hB, 10, LAT, 4'hB, -1, 4'h0);
        check("t6_level", 16'(btn_level), 16'h000B);
        run_seg("t6_release", 4'h0, 10, -1, 4'h0, LAT, 4'hB);

        check("sb_drained", 16'(sb_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
